// File: rtl/regfile_wb_queue.sv
// rtl/regfile_wb_queue.sv - register-file write-back queue with load/ALU arbitration and forwarding lookup
module regfile_wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mem_valid,
  input  logic [4:0]               mem_rd,
  input  logic [31:0]              mem_data,
  output logic                     mem_ready,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [31:0]              alu_data,
  output logic                     alu_ready,
  output logic                     RegWrite,
  output logic [4:0]               WriteRegister,
  output logic [31:0]              WriteData,
  input  logic [4:0]               lookup_reg,
  output logic                     lookup_hit,
  output logic [31:0]              lookup_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    rd_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [4:0]    push_rd;
  logic [31:0]   push_data;
  logic [PW-1:0] idx;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  // Readiness looks only at the current occupancy; a same-edge pop never frees a slot early.
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;
  assign push      = (mem_valid && mem_ready) || (alu_valid && alu_ready);
  assign push_rd   = mem_valid ? mem_rd : alu_rd;
  assign push_data = mem_valid ? mem_data : alu_data;
  assign pop       = !empty;

  // Storage is left uninitialised; entries are only meaningful between rd_ptr and count.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]   <= push_rd;
      data_mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr        <= rd_ptr + PW'(1);
        RegWrite      <= 1'b1;
        WriteRegister <= rd_mem[rd_ptr];
        WriteData     <= data_mem[rd_ptr];
      end else begin
        RegWrite <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Scan oldest to youngest so the last match wins; the output register is older than any queued entry.
  always_comb begin
    idx         = '0;
    lookup_hit  = RegWrite && (WriteRegister == lookup_reg);
    lookup_data = lookup_hit ? WriteData : '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((CW'(i) < count) && (rd_mem[idx] == lookup_reg)) begin
        lookup_hit  = 1'b1;
        lookup_data = data_mem[idx];
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb/tb_regfile_wb_queue.sv - scoreboard bench for regfile_wb_queue
module tb_regfile_wb_queue;
  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   mem_valid, alu_valid;
  logic [4:0]             mem_rd, alu_rd, lookup_reg;
  logic [31:0]            mem_data, alu_data;
  logic                   mem_ready, alu_ready, RegWrite, lookup_hit, empty, full;
  logic [4:0]             WriteRegister;
  logic [31:0]            WriteData, lookup_data;
  logic [$clog2(DEPTH):0] count;

  int n_chk  = 0;
  int n_fail = 0;

  ent_t        m_q[$];
  ent_t        exp_q[$];
  logic        m_out_v;
  logic [4:0]  m_out_rd;
  logic [31:0] m_out_data;
  ent_t        m_e, s_e;
  logic        m_acc_mem, m_acc_alu;

  regfile_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .lookup_reg(lookup_reg), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending writes; each edge moves the oldest to the output stage first.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      exp_q.delete();
      m_out_v    = 1'b0;
      m_out_rd   = '0;
      m_out_data = '0;
    end else begin
      m_acc_mem = mem_valid && (m_q.size() < DEPTH);
      m_acc_alu = alu_valid && !mem_valid && (m_q.size() < DEPTH);
      if (m_q.size() > 0) begin
        m_e        = m_q.pop_front();
        m_out_v    = 1'b1;
        m_out_rd   = m_e.rd;
        m_out_data = m_e.data;
      end else begin
        m_out_v = 1'b0;
      end
      if (m_acc_mem) begin
        m_e.rd = mem_rd; m_e.data = mem_data;
        m_q.push_back(m_e); exp_q.push_back(m_e);
      end else if (m_acc_alu) begin
        m_e.rd = alu_rd; m_e.data = alu_data;
        m_q.push_back(m_e); exp_q.push_back(m_e);
      end
    end
  end

  // Monitor: compare status against the model and pop the scoreboard on every issued write.
  always @(negedge clk) begin
    automatic int          sz = m_q.size();
    automatic logic        lh = 1'b0;
    automatic logic [31:0] ld = '0;
    chk("count", 32'(count), 32'(sz));
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("full", 32'(full), 32'(sz == DEPTH));
    chk("mem_ready", 32'(mem_ready), 32'(sz < DEPTH));
    chk("alu_ready", 32'(alu_ready), 32'((sz < DEPTH) && !mem_valid));
    chk("RegWrite", 32'(RegWrite), 32'(m_out_v));
    chk("WriteRegister", 32'(WriteRegister), 32'(m_out_rd));
    chk("WriteData", WriteData, m_out_data);
    if (RegWrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("issue_unexpected", 32'd1, 32'd0);
      end else begin
        s_e = exp_q.pop_front();
        chk("issue_rd", 32'(WriteRegister), 32'(s_e.rd));
        chk("issue_data", WriteData, s_e.data);
      end
    end
    if (m_out_v && m_out_rd == lookup_reg) begin lh = 1'b1; ld = m_out_data; end
    foreach (m_q[i]) if (m_q[i].rd == lookup_reg) begin lh = 1'b1; ld = m_q[i].data; end
    chk("lookup_hit", 32'(lookup_hit), 32'(lh));
    chk("lookup_data", lookup_data, ld);
  end

  task automatic cyc(input logic mv, input logic [4:0] mr, input logic [31:0] md,
                     input logic av, input logic [4:0] ar, input logic [31:0] ad);
    mem_valid = mv; mem_rd = mr; mem_data = md;
    alu_valid = av; alu_rd = ar; alu_data = ad;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lookup_reg = 5'd3;
    #1;
    chk("reset_mem_ready", 32'(mem_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_empty", 32'(empty), 32'd1);

    // single ALU write: latency of two edges
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h11);
    chk("lat_count1", 32'(count), 32'd1);
    chk("lat_regwrite1", 32'(RegWrite), 32'd0);
    idle();
    chk("lat_regwrite2", 32'(RegWrite), 32'd1);
    chk("lat_wreg2", 32'(WriteRegister), 32'd3);
    chk("lat_wdata2", WriteData, 32'h11);
    chk("lat_count2", 32'(count), 32'd0);
    idle();

    // both ports at once: load wins
    mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 32'hAA;
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'hBB;
    #1;
    chk("arb_alu_ready", 32'(alu_ready), 32'd0);
    chk("arb_mem_ready", 32'(mem_ready), 32'd1);
    @(posedge clk); #1;
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'hBB);
    chk("arb_first_rd", 32'(WriteRegister), 32'd5);
    idle();
    chk("arb_second_rd", 32'(WriteRegister), 32'd6);
    chk("arb_second_data", WriteData, 32'hBB);
    idle();

    // back-to-back pushes wrap the pointers
    for (int i = 0; i < 7; i++)
      cyc(i[0], 5'(i + 10), 32'(100 + i), !i[0], 5'(i + 20), 32'(200 + i));
    idle(); idle();

    // forwarding picks the youngest match
    cyc(1'b1, 5'd7, 32'h1, 1'b0, 5'd0, 32'd0);
    cyc(1'b1, 5'd7, 32'h2, 1'b0, 5'd0, 32'd0);
    mem_valid = 1'b0;
    lookup_reg = 5'd7; #1;
    chk("fwd_hit7", 32'(lookup_hit), 32'd1);
    chk("fwd_data7", lookup_data, 32'h2);
    lookup_reg = 5'd9; #1;
    chk("fwd_hit9", 32'(lookup_hit), 32'd0);
    chk("fwd_data9", lookup_data, 32'd0);
    @(posedge clk); #1;
    idle(); idle();

    // asynchronous reset mid-operation
    cyc(1'b1, 5'd1, 32'h111, 1'b0, 5'd0, 32'd0);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h222);
    mem_valid = 1'b0; alu_valid = 1'b0; lookup_reg = 5'd2;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_regwrite", 32'(RegWrite), 32'd0);
    chk("rst_wreg", 32'(WriteRegister), 32'd0);
    chk("rst_wdata", WriteData, 32'd0);
    chk("rst_lookup_hit", 32'(lookup_hit), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("rst_no_pulse", 32'(RegWrite), 32'd0);
    end

    // register zero is written like any other
    cyc(1'b1, 5'd0, 32'h5, 1'b0, 5'd0, 32'd0);
    idle();
    chk("r0_regwrite", 32'(RegWrite), 32'd1);
    chk("r0_wreg", 32'(WriteRegister), 32'd0);
    chk("r0_wdata", WriteData, 32'h5);
    idle();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      lookup_reg = 5'($urandom_range(0, 7));
      cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom());
    end
    repeat (DEPTH + 3) idle();
    chk("drain_scoreboard", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
